mcyc_ctrl: RTL and testbench
============================

# mcyc_ctrl

Parametrised multicycle MIPS control unit: next generation of the lab multicycle controller. Adds a memory ready/request handshake with wait states, BNE, ANDI/ORI/SLTI, an immediate zero-extend select, and a sticky illegal-instruction halt. It sits between the instruction register fields (op, funct) plus ALU zero flag and the multicycle datapath, driving all datapath enables and mux selects.

## Interface
Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored, each memory state lasts one cycle
- ALUC_W, 3, alucontrol width (values below are 3-bit; zero-extend if wider)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- memreq  out  1  memory access requested
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = A
- iord  out  1  0 = PC address, 1 = ALUOut address
- memtoreg  out  1  1 = write-back from Data register
- regdst  out  1  1 = rd, 0 = rt
- immzext  out  1  1 = zero-extend immediate, 0 = sign-extend
- alusrcb  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- alucontrol  out  ALUC_W  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  sticky: unsupported op/funct decoded
- state_dbg  out  4  current state encoding

## Operation
- States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, BNEEX 9, IMMEX 10, IMMWB 11, JEX 12, HALT 13; 14/15 → FETCH.
- Transitions: FETCH→DECODE on ready. DECODE: lw/sw(100011/101011)→MEMADR; R-type(000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010→RTYPEEX; beq 000100→BEQEX; bne 000101→BNEEX; addi 001000, andi 001100, ori 001101, slti 001010→IMMEX; j 000010→JEX; any other op or R-type funct→HALT. MEMADR→MEMRD (lw) / MEMWR (sw). MEMRD→MEMWB on ready. MEMWR→FETCH on ready. RTYPEEX→RTYPEWB; IMMEX→IMMWB; MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX→FETCH. HALT→HALT until reset.
- "ready" = mem_ready when MEM_HANDSHAKE=1, else constant 1.
- Outputs not listed for a state are 0:
- FETCH: memreq, alusrcb=01, add; irwrite=pcwrite=ready.
- DECODE: alusrcb=11, add.
- MEMADR: alusrca, alusrcb=10, add.
- MEMRD: memreq, iord. MEMWR: memreq, iord, memwrite (held every cycle until ready).
- MEMWB: regwrite, memtoreg. RTYPEEX: alusrca, alucontrol from funct. RTYPEWB: regwrite, regdst.
- BEQEX/BNEEX: alusrca, sub, pcsrc=01, branch-eq/branch-ne internal.
- IMMEX: alusrca, alusrcb=10; addi add, andi and (immzext), ori or (immzext), slti slt. IMMWB: regwrite; immzext and alucontrol held from IMMEX.
- JEX: pcsrc=10, pcwrite.
- pcen = pcwrite | (beq & zero) | (bne & ~zero).
- illegal = 1 in HALT; cleared only by reset.

## Timing
- Async reset: state←FETCH, illegal←0 immediately; while reset_n=0 every output is forced to 0 (including memreq); first FETCH request on first clk edge after release, outputs valid from the deassertion combinationally.
- State outputs are Moore; irwrite/pcen in FETCH and pcen in branch states are Mealy on mem_ready/zero.
- CPI with zero wait: lw 5, sw 4, R-type 4, imm 4, beq/bne 3, j 3. Each mem_ready-low cycle adds one.
- mem_ready outside memreq cycles is ignored. Reset asserted mid-MEMWR drops memwrite in the same cycle.

## Structure
- Package mcyc_pkg: state enum, opcode/funct constants, alucontrol constants, internal aluop enum.
- One sub-module: mcyc_aludec (combinational aluop+funct → alucontrol, funct-legal flag), reused by DECODE legality check.

## Test plan
- Reset, mem_ready=1, lw (op 100011): states 0,1,2,3,4,0; regwrite&memtoreg only in MEMWB; 5 cycles.
- MEM_HANDSHAKE=1, mem_ready low 3 cycles in FETCH: stays FETCH, memreq=1, irwrite=pcen=0 until ready, then DECODE.
- bne with zero=0 → pcen=1, pcsrc=01; with zero=1 → pcen=0; beq mirror.
- ori: IMMEX alucontrol=001, immzext=1; IMMWB regwrite=1, regdst=0.
- op 111111 or R-type funct 000111: HALT, illegal=1, all enables 0 for 20 cycles; reset_n low clears.
- reset_n low during MEMWR with mem_ready=0: memwrite drops immediately; after release state=FETCH.

Source files
------------

// File: rtl/mcyc_pkg.sv
// ---------------------------------------------------------------------------
// mcyc_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t : FSM state encoding (also exported on state_dbg)
//   - aluop_t : internal ALU operation class handed to the ALU decoder
//   - ctrl_t  : bundle of raw (pre-reset-gating) datapath controls
//   - opcode, funct and alucontrol constants
//   - immediate-instruction helpers shared by decode and output logic
// ---------------------------------------------------------------------------
package mcyc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  // ALUOP_NONE is the idle class: states that do not use the ALU drive 000.
  typedef enum logic [2:0] {
    ALUOP_NONE  = 3'd0,
    ALUOP_ADD   = 3'd1,
    ALUOP_SUB   = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4,
    ALUOP_SLT   = 3'd5,
    ALUOP_FUNCT = 3'd6
  } aluop_t;

  typedef struct packed {
    logic       memreq;
    logic       pcwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       immzext;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // 3-bit alucontrol encodings
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  function automatic aluop_t imm_aluop(input logic [5:0] op);
    aluop_t r;
    case (op)
      OP_ANDI: r = ALUOP_AND;
      OP_ORI:  r = ALUOP_OR;
      OP_SLTI: r = ALUOP_SLT;
      default: r = ALUOP_ADD;
    endcase
    return r;
  endfunction

  // Logical immediates are zero-extended; arithmetic/compare ones sign-extended.
  function automatic logic imm_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mcyc_aludec.sv
// ---------------------------------------------------------------------------
// mcyc_aludec
// Combinational ALU decoder. Maps the FSM's ALU operation class (and, for
// R-type execute, the funct field) to the 3-bit alucontrol code. Also flags
// whether funct is a supported R-type function; that flag depends on funct
// only, so the controller uses it for the DECODE legality check regardless
// of which aluop is currently selected.
//
// Ports:
//   aluop       in  aluop_t  operation class from the controller
//   funct       in  6        instr[5:0]
//   alucontrol  out 3        ALU operation code
//   funct_legal out 1        funct is add/sub/and/or/slt
// ---------------------------------------------------------------------------
module mcyc_aludec
  import mcyc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_legal
);

  logic [2:0] funct_aluc;

  always_comb begin
    funct_aluc  = ALUC_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  funct_aluc = ALUC_ADD;
      FN_SUB:  funct_aluc = ALUC_SUB;
      FN_AND:  funct_aluc = ALUC_AND;
      FN_OR:   funct_aluc = ALUC_OR;
      FN_SLT:  funct_aluc = ALUC_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALUC_ADD;
      ALUOP_SUB:   alucontrol = ALUC_SUB;
      ALUOP_AND:   alucontrol = ALUC_AND;
      ALUOP_OR:    alucontrol = ALUC_OR;
      ALUOP_SLT:   alucontrol = ALUC_SLT;
      ALUOP_FUNCT: alucontrol = funct_aluc;
      default:     alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mcyc_ctrl.sv
// ---------------------------------------------------------------------------
// mcyc_ctrl
// Multicycle MIPS control unit. Sequences fetch/decode/execute/memory/
// write-back for lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, andi,
// ori, slti and j, with a memory ready/request handshake that inserts wait
// states in FETCH, MEMRD and MEMWR. Unsupported instructions park the FSM in
// HALT with a sticky illegal flag until reset.
//
// Parameters:
//   MEM_HANDSHAKE  1: memory states wait for mem_ready; 0: one cycle each
//   ALUC_W         alucontrol width (3-bit codes zero-extended)
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   op, funct         instruction register fields
//   zero              ALU result == 0 (branch resolution)
//   mem_ready         memory completes the current request this cycle
//   memreq, memwrite  memory request / write strobe
//   pcen, irwrite     PC and instruction register enables
//   regwrite          register file write
//   alusrca, alusrcb  ALU operand selects
//   iord              memory address select (PC / ALUOut)
//   memtoreg, regdst  write-back data / destination selects
//   immzext           zero-extend the immediate
//   pcsrc             next-PC select
//   alucontrol        ALU operation
//   illegal           sticky unsupported-instruction flag
//   state_dbg         current state encoding
// ---------------------------------------------------------------------------
module mcyc_ctrl
  import mcyc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALUC_W        = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              memreq,
  output logic              pcen,
  output logic              memwrite,
  output logic              irwrite,
  output logic              regwrite,
  output logic              alusrca,
  output logic              iord,
  output logic              memtoreg,
  output logic              regdst,
  output logic              immzext,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              illegal,
  output logic [3:0]        state_dbg
);

  state_t     state, state_n;
  logic       illegal_q;
  logic       ready;
  ctrl_t      c;
  logic [2:0] aluc3;
  logic       funct_legal;
  logic       pcen_raw;

  // Without the handshake every memory access completes in one cycle.
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  mcyc_aludec u_aludec (
    .aluop       (c.aluop),
    .funct       (funct),
    .alucontrol  (aluc3),
    .funct_legal (funct_legal)
  );

  // State register; illegal latches on entry to HALT and only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == S_HALT) illegal_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (ready) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = funct_legal ? S_RTYPEEX : S_HALT;
          OP_BEQ:       state_n = S_BEQEX;
          OP_BNE:       state_n = S_BNEEX;
          OP_J:         state_n = S_JEX;
          default:      state_n = is_imm_op(op) ? S_IMMEX : S_HALT;
        endcase
      end
      S_MEMADR:  state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ready) state_n = S_MEMWB;
      S_MEMWR:   if (ready) state_n = S_FETCH;
      S_RTYPEEX: state_n = S_RTYPEWB;
      S_IMMEX:   state_n = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_IMMWB,
      S_BEQEX, S_BNEEX, S_JEX: state_n = S_FETCH;
      S_HALT:    state_n = S_HALT;
      default:   state_n = S_FETCH;
    endcase
  end

  // Output decode: Moore per state, except irwrite/pcwrite in FETCH which
  // follow ready so the IR and PC only load when the fetch completes.
  always_comb begin
    c       = '0;
    c.aluop = ALUOP_NONE;
    case (state)
      S_FETCH: begin
        c.memreq  = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
        c.irwrite = ready;
        c.pcwrite = ready;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memreq = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEMWR: begin
        c.memreq   = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca   = 1'b1;
        c.aluop     = ALUOP_SUB;
        c.pcsrc     = 2'b01;
        c.branch_eq = 1'b1;
      end
      S_BNEEX: begin
        c.alusrca   = 1'b1;
        c.aluop     = ALUOP_SUB;
        c.pcsrc     = 2'b01;
        c.branch_ne = 1'b1;
      end
      S_IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = imm_aluop(op);
        c.immzext = imm_zext(op);
      end
      S_IMMWB: begin
        // IR is stable here, so re-decoding op holds the IMMEX ALU setup.
        c.regwrite = 1'b1;
        c.aluop    = imm_aluop(op);
        c.immzext  = imm_zext(op);
      end
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen_raw = c.pcwrite | (c.branch_eq & zero) | (c.branch_ne & ~zero);

  // Every output is forced low while reset is held, independent of the clock,
  // so a reset in the middle of a write drops memwrite immediately.
  assign memreq     = reset_n & c.memreq;
  assign pcen       = reset_n & pcen_raw;
  assign memwrite   = reset_n & c.memwrite;
  assign irwrite    = reset_n & c.irwrite;
  assign regwrite   = reset_n & c.regwrite;
  assign alusrca    = reset_n & c.alusrca;
  assign iord       = reset_n & c.iord;
  assign memtoreg   = reset_n & c.memtoreg;
  assign regdst     = reset_n & c.regdst;
  assign immzext    = reset_n & c.immzext;
  assign alusrcb    = reset_n ? c.alusrcb : 2'b00;
  assign pcsrc      = reset_n ? c.pcsrc : 2'b00;
  assign alucontrol = reset_n ? ALUC_W'(aluc3) : '0;
  assign illegal    = reset_n & illegal_q;
  assign state_dbg  = reset_n ? state : 4'd0;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcyc_ctrl
// Scoreboard bench for mcyc_ctrl. A reference model expands each instruction
// into its cycle-by-cycle list of expected control outputs (with memory wait
// cycles inserted); a driver applies the inputs for each cycle and queues the
// expected outputs, and a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_mcyc_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       memreq, pcen, memwrite, irwrite, regwrite, alusrca, iord;
    logic       memtoreg, regdst, immzext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    obs_t       exp;
  } rec_t;

  logic       clk;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       memreq, pcen, memwrite, irwrite, regwrite, alusrca, iord;
  logic       memtoreg, regdst, immzext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;
  obs_t       act;

  rec_t       drvq[$];
  obs_t       sbq[$];
  int         total, bad;
  bit         mon_en;
  logic [5:0] cur_op, cur_funct;

  mcyc_ctrl #(.MEM_HANDSHAKE(1'b1), .ALUC_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .memreq(memreq), .pcen(pcen), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .immzext(immzext), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state_dbg(state_dbg)
  );

  assign act = {state_dbg, memreq, pcen, memwrite, irwrite, regwrite, alusrca, iord,
                memtoreg, regdst, immzext, illegal, alusrcb, pcsrc, alucontrol};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: act=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  // ALU code of a supported R-type funct, -1 otherwise
  function automatic int rt_aluc(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  // ALU code of an immediate opcode, -1 otherwise
  function automatic int imm_aluc(input logic [5:0] o);
    case (o)
      6'b001000: return 2;
      6'b001100: return 0;
      6'b001101: return 1;
      6'b001010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b000101) || (o == 6'b000010) ||
           (imm_aluc(o) >= 0);
  endfunction

  task automatic push(input obs_t e, input logic rdy, input logic z);
    rec_t r;
    r.op = cur_op; r.funct = cur_funct; r.zero = z; r.rdy = rdy; r.exp = e;
    drvq.push_back(r);
  endtask

  // Expand one instruction into per-cycle expectations.
  task automatic model_instr(input logic [5:0] o, input logic [5:0] f, input logic bz,
                             input int fw, input int mw, input bit abort_wr,
                             output bit need_rst);
    obs_t e;
    int   ra, ia;
    cur_op = o; cur_funct = f; need_rst = 1'b0;
    ra = rt_aluc(f);
    ia = imm_aluc(o);
    e = blank(4'd0); e.memreq = 1'b1; e.alusrcb = 2'b01; e.aluc = 3'b010;
    repeat (fw) push(e, 1'b0, rb());
    e.irwrite = 1'b1; e.pcen = 1'b1;
    push(e, 1'b1, rb());
    e = blank(4'd1); e.alusrcb = 2'b11; e.aluc = 3'b010;
    push(e, rb(), rb());
    if (o == 6'b100011 || o == 6'b101011) begin
      e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'b010;
      push(e, rb(), rb());
      if (o == 6'b100011) begin
        e = blank(4'd3); e.memreq = 1'b1; e.iord = 1'b1;
        repeat (mw) push(e, 1'b0, rb());
        push(e, 1'b1, rb());
        e = blank(4'd4); e.regwrite = 1'b1; e.memtoreg = 1'b1;
        push(e, rb(), rb());
      end else begin
        e = blank(4'd5); e.memreq = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1;
        repeat (mw) push(e, 1'b0, rb());
        if (abort_wr) need_rst = 1'b1;
        else push(e, 1'b1, rb());
      end
    end else if (o == 6'b000000 && ra >= 0) begin
      e = blank(4'd6); e.alusrca = 1'b1; e.aluc = 3'(ra);
      push(e, rb(), rb());
      e = blank(4'd7); e.regwrite = 1'b1; e.regdst = 1'b1;
      push(e, rb(), rb());
    end else if (o == 6'b000100 || o == 6'b000101) begin
      e = blank(o[0] ? 4'd9 : 4'd8);
      e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01;
      e.pcen = o[0] ? ~bz : bz;
      push(e, rb(), bz);
    end else if (ia >= 0) begin
      e = blank(4'd10); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluc = 3'(ia);
      e.immzext = (o == 6'b001100) || (o == 6'b001101);
      push(e, rb(), rb());
      e.st = 4'd11; e.alusrca = 1'b0; e.alusrcb = 2'b00; e.regwrite = 1'b1;
      push(e, rb(), rb());
    end else if (o == 6'b000010) begin
      e = blank(4'd12); e.pcsrc = 2'b10; e.pcen = 1'b1;
      push(e, rb(), rb());
    end else begin
      e = blank(4'd13); e.illegal = 1'b1;
      repeat (20) push(e, rb(), rb());
      need_rst = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: act=%h required=%h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (mon_en && sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle t=%0t op=%b st_req=%0d: act=%h required=%h",
                 $time, op, e.st, act, e);
      end
    end
  end

  // ---------------- driving ----------------
  task automatic drive_all();
    rec_t r;
    while (drvq.size() > 0) begin
      r = drvq.pop_front();
      @(posedge clk); #1;
      op = r.op; funct = r.funct; zero = r.zero; mem_ready = r.rdy;
      sbq.push_back(r.exp);
    end
  endtask

  task automatic reset_pulse(input bit in_memwr);
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    if (in_memwr) begin
      chk("memwr_hold_state", 32'(state_dbg), 32'd5);
      chk("memwr_hold_we", 32'(memwrite), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("rst_all_zero", 32'(act), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    #1;
    chk("rel_state", 32'(state_dbg), 32'd0);
    chk("rel_memreq", 32'(memreq), 32'd1);
    chk("rel_illegal", 32'(illegal), 32'd0);
    chk("rel_alusrcb", 32'(alusrcb), 32'd1);
    mon_en = 1'b1;
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic bz,
                     input int fw, input int mw, input bit abort_wr);
    bit nr;
    model_instr(o, f, bz, fw, mw, abort_wr, nr);
    drive_all();
    if (nr) reset_pulse(abort_wr);
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [5];

  initial begin
    total = 0; bad = 0; mon_en = 1'b0;
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    repeat (2) @(posedge clk);
    reset_pulse(1'b0);

    // directed cases
    run(6'b100011, 6'b000000, 1'b0, 0, 0, 1'b0);   // lw, no waits
    run(6'b000000, 6'b100000, 1'b0, 3, 0, 1'b0);   // add, 3 fetch waits
    run(6'b000101, 6'b000000, 1'b0, 0, 0, 1'b0);   // bne taken
    run(6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0);   // bne not taken
    run(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);   // beq taken
    run(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0);   // beq not taken
    run(6'b001101, 6'b000000, 1'b0, 0, 0, 1'b0);   // ori
    run(6'b101011, 6'b000000, 1'b0, 1, 2, 1'b0);   // sw with waits
    run(6'b100011, 6'b000000, 1'b0, 2, 2, 1'b0);   // lw with waits
    run(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);   // illegal opcode
    run(6'b000000, 6'b000111, 1'b0, 0, 0, 1'b0);   // illegal funct
    run(6'b101011, 6'b000000, 1'b0, 0, 1, 1'b1);   // reset during MEMWR

    // randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      int         k;
      logic [5:0] o, f;
      k = int'($urandom_range(0, 21));
      f = 6'($urandom);
      if (k < 20) begin
        o = ops[$urandom_range(0, 9)];
        if (o == 6'b000000) f = fns[$urandom_range(0, 4)];
      end else if (k == 20) begin
        o = 6'b000000;
        while (rt_aluc(f) >= 0) f = 6'($urandom);
      end else begin
        o = 6'($urandom);
        while (legal_op(o)) o = 6'($urandom);
      end
      run(o, f, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
    end

    @(negedge clk); #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
